valu_element_sequencer: RTL and testbench
=========================================

Name: valu_element_sequencer

Overview:
- Upstream issue/writeback stage for the vector ALU datapath. Accepts one vector ALU instruction at a time and walks it element by element.
- Per element: reads operands from the vector register file, drives the ALU operands and control fields, and writes the result back.
- Collects the per-element comparison predicates into a mask register.
- Throughput: one element per cycle, with a fixed 3-stage pipeline (read, execute, write).

Parameters:
- WIDTH, 32, element width; matches ALU WIDTH.
- NUM_VREGS, 32, number of vector registers.
- MAX_VL, 8, maximum elements per vector; power of two.
- Derived (localparam): RW = log2(NUM_VREGS), EW = log2(MAX_VL), VLW = log2(MAX_VL)+1, AW = RW+EW.

Ports:
- clk  in  1  clock; all state on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  sequencer can accept; high only in IDLE.
- instr_vl  in  VLW  element count, 0..MAX_VL; values above MAX_VL are clamped to MAX_VL.
- instr_vd, instr_vs1, instr_vs2  in  RW each  destination and source registers.
- instr_scalar_en  in  1  1: second operand is instr_scalar (ALU C path).
- instr_scalar  in  WIDTH  scalar operand.
- instr_addsub, instr_outctl[3], instr_bwctl[2], instr_cmpctl[2], instr_cmp_en[1]  in  ALU controls, latched on accept.
- rf_rd_en  out  1  register-file read strobe.
- rf_rd_addr_a, rf_rd_addr_b  out  AW  {vreg, element index}.
- rf_rd_data_a, rf_rd_data_b  in  WIDTH  read data, valid the cycle after rf_rd_en.
- alu_a, alu_b, alu_c  out  WIDTH  ALU operands.
- alu_addsub, alu_mux, alu_outctl, alu_bwctl, alu_cmpctl  out  ALU control fields.
- alu_result  in  WIDTH  ALU finalResult.
- alu_predicate  in  1  ALU predicate.
- rf_wr_en  out  1  write strobe.
- rf_wr_addr  out  AW  write address.
- rf_wr_data  out  WIDTH  write data.
- mask_out  out  MAX_VL  predicate mask register.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset values: instr_ready=1 (IDLE), rf_rd_en=0, rf_wr_en=0, done=0, mask_out=0. All address, data and control outputs = 0.
- Reset asserted mid-instruction: immediate return to IDLE. No further reads or writes; in-flight elements are discarded.
- States:
  - IDLE: instr_valid&instr_ready latches all instr_* fields and clears the element counter.
    - vl==0: go to DRAIN.
    - Otherwise: go to RUN.
  - RUN: each cycle issues rf_rd_en=1 with rf_rd_addr_a={vs1,i} and rf_rd_addr_b={vs2,i}, then increments i. After issuing element vl-1, go to DRAIN.
  - DRAIN: wait until the pipeline is empty, assert done for one cycle, then go to IDLE.
- Pipeline, element i read in cycle t:
  - Cycle t+1 (execute): alu_a=rf_rd_data_a and alu_b=rf_rd_data_b combinationally; alu_c=latched scalar; alu_mux=scalar_en. alu_result and alu_predicate are registered at the end of t+1.
  - Cycle t+2 (write): rf_wr_en=1, rf_wr_addr={vd,i}, rf_wr_data=registered result.
  - If cmp_en: mask_out[i] is updated with the predicate in t+2 and rf_wr_en stays 0 for that element.
- ALU control outputs are held constant from accept until done.
- Timing for vl=N, accepted at cycle 0:
  - Reads occur in cycles 1..N; writes in cycles 3..N+2.
  - done is asserted in cycle N+3; instr_ready returns in cycle N+4.
  - vl=0: done is asserted in cycle 2; there are no reads or writes.
- mask_out: all bits are cleared at accept when cmp_en=1. Bits at index >= vl stay 0. When cmp_en=0, mask_out keeps its previous value.
- Hazard: vd may equal vs1 or vs2. Element i is read before it is written (read at t_i, write at t_i+2), so in-place operations are correct with no interlock.
- Element index wraps only through the counter limit vl. Any overflow of EW bits beyond MAX_VL is prevented by the clamp.

Optional Feature:
- Macro: VALU_MASKED_EXEC_EN.
- When defined:
  - Adds input instr_mask_en[1], latched on accept.
  - When instr_mask_en=1, element i's register-file write is suppressed if mask_out[i]==0, using the mask value held at accept.
  - Reads and timing are unchanged.
  - cmp_en together with mask_en updates only the bits whose old mask bit is 1.
- When not defined: the port is absent and all elements are written.

Test Plan:
- Add: vl=4, vs1 elements {1,2,3,4}, vs2 {10,20,30,40}, outctl=000, addsub=0 -> vd={11,22,33,44}. Writes in cycles 3..6, done in cycle 7.
- Scalar subtract: vl=8, scalar_en=1, scalar=5, vs1 element i = i+5 -> alu_mux=1, vd element i = i, done in cycle 11.
- Compare: cmp_en=1, vl=6, vs1=vs2 for elements 0,2,4 only, equality cmpctl -> mask_out=8'b00010101, rf_wr_en never asserted.
- vl=0 and vl=15 (clamped): vl=0 -> done in cycle 2 with no rf strobes; vl=15 -> exactly 8 reads and 8 writes.
- Reset asserted in cycle 3 of a vl=8 add -> outputs at reset values next edge, no further rf_wr_en, instr_ready=1. A new instruction then runs correctly.
- VALU_MASKED_EXEC_EN: mask_out=8'hA5, mask_en=1, vl=8 add -> writes only to elements 0,2,5,7; other elements of vd unchanged.

Source files
------------

// File: rtl/valu_element_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : valu_element_sequencer
//  Description : Issue/writeback sequencer for the vector ALU. Accepts one
//                instruction at a time and streams its elements through a
//                fixed read -> execute -> write pipeline, one element per
//                cycle, collecting compare predicates into a mask register.
//                Optional masked execution is enabled by defining
//                VALU_MASKED_EXEC_EN (adds the instr_mask_en input).
//  Revision    : 1.0 - initial release
// ============================================================================
module valu_element_sequencer #(
    parameter int  WIDTH     = 32,
    parameter int  NUM_VREGS = 32,
    parameter int  MAX_VL    = 8,
    localparam int RW        = $clog2(NUM_VREGS),
    localparam int EW        = $clog2(MAX_VL),
    localparam int VLW       = EW + 1,
    localparam int AW        = RW + EW
) (
    input  logic              clk,
    input  logic              reset,
    // instruction channel
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [VLW-1:0]    instr_vl,
    input  logic [RW-1:0]     instr_vd,
    input  logic [RW-1:0]     instr_vs1,
    input  logic [RW-1:0]     instr_vs2,
    input  logic              instr_scalar_en,
    input  logic [WIDTH-1:0]  instr_scalar,
    input  logic              instr_addsub,
    input  logic [2:0]        instr_outctl,
    input  logic [1:0]        instr_bwctl,
    input  logic [1:0]        instr_cmpctl,
    input  logic              instr_cmp_en,
`ifdef VALU_MASKED_EXEC_EN
    input  logic              instr_mask_en,
`endif
    // register-file read port
    output logic              rf_rd_en,
    output logic [AW-1:0]     rf_rd_addr_a,
    output logic [AW-1:0]     rf_rd_addr_b,
    input  logic [WIDTH-1:0]  rf_rd_data_a,
    input  logic [WIDTH-1:0]  rf_rd_data_b,
    // ALU interface
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [WIDTH-1:0]  alu_c,
    output logic              alu_addsub,
    output logic              alu_mux,
    output logic [2:0]        alu_outctl,
    output logic [1:0]        alu_bwctl,
    output logic [1:0]        alu_cmpctl,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic              alu_predicate,
    // register-file write port
    output logic              rf_wr_en,
    output logic [AW-1:0]     rf_wr_addr,
    output logic [WIDTH-1:0]  rf_wr_data,
    // status
    output logic [MAX_VL-1:0] mask_out,
    output logic              done
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;

    // control state
    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic              r_drain_seen;
    logic [EW-1:0]     r_idx;

    // latched instruction
    logic [VLW-1:0]    r_vl;
    logic [RW-1:0]     r_vd;
    logic [RW-1:0]     r_vs1;
    logic [RW-1:0]     r_vs2;
    logic              r_scalar_en;
    logic [WIDTH-1:0]  r_scalar;
    logic              r_addsub;
    logic [2:0]        r_outctl;
    logic [1:0]        r_bwctl;
    logic [1:0]        r_cmpctl;
    logic              r_cmp_en;

    // pipeline
    logic              r_ex_vld;
    logic [EW-1:0]     r_ex_idx;
    logic              r_wb_vld;
    logic [EW-1:0]     r_wb_idx;
    logic [WIDTH-1:0]  r_wb_result;
    logic              r_wb_pred;
    logic [MAX_VL-1:0] r_mask;

    logic              w_accept;
    logic              w_issue;
    logic              w_last;
    logic              w_lane_en;
    logic [VLW-1:0]    w_vl_clamped;

    // Element counts above MAX_VL are clamped so the EW-bit index never overruns.
    assign w_vl_clamped = (instr_vl > VLW'(MAX_VL)) ? VLW'(MAX_VL) : instr_vl;
    assign w_accept     = instr_valid && (r_state == c_st_idle);
    assign w_issue      = (r_state == c_st_run);
    assign w_last       = w_issue && ({1'b0, r_idx} == (r_vl - VLW'(1)));

`ifdef VALU_MASKED_EXEC_EN
    logic              r_mask_en;
    logic [MAX_VL-1:0] r_mask_hold;

    // Mask-enable and the mask snapshot taken at accept gate each element.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mask_en   <= 1'b0;
            r_mask_hold <= '0;
        end else if (w_accept) begin
            r_mask_en   <= instr_mask_en;
            r_mask_hold <= r_mask;
        end
    end

    assign w_lane_en = ~r_mask_en | r_mask_hold[r_wb_idx];
`else
    assign w_lane_en = 1'b1;
`endif

    // State register plus a flag marking that DRAIN has lasted over one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_drain_seen <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_drain_seen <= (r_state == c_st_drain);
        end
    end

    // Next-state and handshake/strobe decode.
    always_comb begin
        w_next_state = r_state;
        instr_ready  = 1'b0;
        rf_rd_en     = 1'b0;
        done         = 1'b0;
        case (r_state)
            c_st_idle: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    w_next_state = (w_vl_clamped == '0) ? c_st_drain : c_st_run;
                end
            end
            c_st_run: begin
                rf_rd_en = 1'b1;
                if (w_last) begin
                    w_next_state = c_st_drain;
                end
            end
            c_st_drain: begin
                // The extra DRAIN cycle keeps vl=0 completion aligned with the
                // nonzero case; otherwise wait for both pipeline stages to empty.
                if (r_drain_seen && !r_ex_vld && !r_wb_vld) begin
                    done         = 1'b1;
                    w_next_state = c_st_idle;
                end
            end
            default: w_next_state = c_st_idle;
        endcase
    end

    // Latch the instruction on accept and step the element index while issuing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vl        <= '0;
            r_vd        <= '0;
            r_vs1       <= '0;
            r_vs2       <= '0;
            r_scalar_en <= 1'b0;
            r_scalar    <= '0;
            r_addsub    <= 1'b0;
            r_outctl    <= '0;
            r_bwctl     <= '0;
            r_cmpctl    <= '0;
            r_cmp_en    <= 1'b0;
            r_idx       <= '0;
        end else if (w_accept) begin
            r_vl        <= w_vl_clamped;
            r_vd        <= instr_vd;
            r_vs1       <= instr_vs1;
            r_vs2       <= instr_vs2;
            r_scalar_en <= instr_scalar_en;
            r_scalar    <= instr_scalar;
            r_addsub    <= instr_addsub;
            r_outctl    <= instr_outctl;
            r_bwctl     <= instr_bwctl;
            r_cmpctl    <= instr_cmpctl;
            r_cmp_en    <= instr_cmp_en;
            r_idx       <= '0;
        end else if (w_issue) begin
            r_idx       <= r_idx + EW'(1);
        end
    end

    // Execute and write stages: element index rides alongside its data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ex_vld    <= 1'b0;
            r_ex_idx    <= '0;
            r_wb_vld    <= 1'b0;
            r_wb_idx    <= '0;
            r_wb_result <= '0;
            r_wb_pred   <= 1'b0;
        end else begin
            r_ex_vld <= w_issue;
            r_ex_idx <= r_idx;
            r_wb_vld <= r_ex_vld;
            r_wb_idx <= r_ex_idx;
            if (r_ex_vld) begin
                r_wb_result <= alu_result;
                r_wb_pred   <= alu_predicate;
            end
        end
    end

    // Predicate mask: cleared by a compare accept, filled as compare elements retire.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mask <= '0;
        end else if (w_accept && instr_cmp_en) begin
            r_mask <= '0;
        end else if (r_wb_vld && r_cmp_en && w_lane_en) begin
            r_mask[r_wb_idx] <= r_wb_pred;
        end
    end

    assign rf_rd_addr_a = {r_vs1, r_idx};
    assign rf_rd_addr_b = {r_vs2, r_idx};

    // Operands are forced to zero outside the execute cycle.
    assign alu_a      = r_ex_vld ? rf_rd_data_a : '0;
    assign alu_b      = r_ex_vld ? rf_rd_data_b : '0;
    assign alu_c      = r_scalar;
    assign alu_mux    = r_scalar_en;
    assign alu_addsub = r_addsub;
    assign alu_outctl = r_outctl;
    assign alu_bwctl  = r_bwctl;
    assign alu_cmpctl = r_cmpctl;

    // Compare instructions report through the mask only, never the register file.
    assign rf_wr_en   = r_wb_vld & ~r_cmp_en & w_lane_en;
    assign rf_wr_addr = {r_vd, r_wb_idx};
    assign rf_wr_data = r_wb_result;
    assign mask_out   = r_mask;

endmodule
`default_nettype wire

// File: tb/tb_valu_element_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_valu_element_sequencer
//  Description : Self-checking bench for valu_element_sequencer. Provides a
//                register-file model and a stand-in ALU, and checks the DUT
//                cycle by cycle against an instruction-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_valu_element_sequencer;

    localparam int WIDTH     = 32;
    localparam int NUM_VREGS = 32;
    localparam int MAX_VL    = 8;
    localparam int RW        = 5;
    localparam int VLW       = 4;
    localparam int AW        = 8;
    localparam int DEPTH     = NUM_VREGS * MAX_VL;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              instr_valid = 1'b0;
    logic              instr_ready;
    logic [VLW-1:0]    instr_vl = '0;
    logic [RW-1:0]     instr_vd = '0, instr_vs1 = '0, instr_vs2 = '0;
    logic              instr_scalar_en = 1'b0;
    logic [WIDTH-1:0]  instr_scalar = '0;
    logic              instr_addsub = 1'b0;
    logic [2:0]        instr_outctl = '0;
    logic [1:0]        instr_bwctl = '0, instr_cmpctl = '0;
    logic              instr_cmp_en = 1'b0;
`ifdef VALU_MASKED_EXEC_EN
    logic              instr_mask_en = 1'b0;
`endif
    logic              rf_rd_en;
    logic [AW-1:0]     rf_rd_addr_a, rf_rd_addr_b;
    logic [WIDTH-1:0]  rf_rd_data_a = '0, rf_rd_data_b = '0;
    logic [WIDTH-1:0]  alu_a, alu_b, alu_c, alu_result, alu_op2;
    logic              alu_addsub, alu_mux, alu_predicate;
    logic [2:0]        alu_outctl;
    logic [1:0]        alu_bwctl, alu_cmpctl;
    logic              rf_wr_en;
    logic [AW-1:0]     rf_wr_addr;
    logic [WIDTH-1:0]  rf_wr_data;
    logic [MAX_VL-1:0] mask_out;
    logic              done;

    valu_element_sequencer #(.WIDTH(WIDTH), .NUM_VREGS(NUM_VREGS), .MAX_VL(MAX_VL)) dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_vl(instr_vl),
        .instr_vd(instr_vd), .instr_vs1(instr_vs1), .instr_vs2(instr_vs2),
        .instr_scalar_en(instr_scalar_en), .instr_scalar(instr_scalar),
        .instr_addsub(instr_addsub), .instr_outctl(instr_outctl), .instr_bwctl(instr_bwctl),
        .instr_cmpctl(instr_cmpctl), .instr_cmp_en(instr_cmp_en),
`ifdef VALU_MASKED_EXEC_EN
        .instr_mask_en(instr_mask_en),
`endif
        .rf_rd_en(rf_rd_en), .rf_rd_addr_a(rf_rd_addr_a), .rf_rd_addr_b(rf_rd_addr_b),
        .rf_rd_data_a(rf_rd_data_a), .rf_rd_data_b(rf_rd_data_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_addsub(alu_addsub), .alu_mux(alu_mux),
        .alu_outctl(alu_outctl), .alu_bwctl(alu_bwctl), .alu_cmpctl(alu_cmpctl),
        .alu_result(alu_result), .alu_predicate(alu_predicate),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .mask_out(mask_out), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Stand-in ALU: add/sub on (a, b-or-c); predicate chosen by cmpctl.
    function automatic logic [WIDTH-1:0] alu_fn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub);
        return sub ? (a - b) : (a + b);
    endfunction

    function automatic logic pred_fn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [1:0] cc);
        case (cc)
            2'd0:    return a == b;
            2'd1:    return a < b;
            2'd2:    return a > b;
            default: return a != b;
        endcase
    endfunction

    always_comb begin
        alu_op2       = alu_mux ? alu_c : alu_b;
        alu_result    = alu_fn(alu_a, alu_op2, alu_addsub);
        alu_predicate = pred_fn(alu_a, alu_op2, alu_cmpctl);
    end

    // Register file: 1-cycle read latency; tb_load copies the reference image in.
    logic [WIDTH-1:0] mem     [DEPTH];
    logic [WIDTH-1:0] ref_mem [DEPTH];
    logic             tb_load = 1'b0;

    always @(posedge clk) begin
        if (tb_load) begin
            for (int j = 0; j < DEPTH; j++) mem[j] <= ref_mem[j];
        end else if (rf_wr_en) begin
            mem[rf_wr_addr] <= rf_wr_data;
        end
        if (rf_rd_en) begin
            rf_rd_data_a <= mem[rf_rd_addr_a];
            rf_rd_data_b <= mem[rf_rd_addr_b];
        end
    end

    int n_rd = 0;
    int n_wr = 0;
    always @(negedge clk) begin
        n_rd += int'(rf_rd_en);
        n_wr += int'(rf_wr_en);
    end

    // Instruction-level model state
    bit                active = 1'b0;
    int                t_acc, m_n, m_vs1, m_vs2, m_vd, done_k, done_at;
    logic [WIDTH-1:0]  m_a [MAX_VL];
    logic [WIDTH-1:0]  m_b [MAX_VL];
    logic [WIDTH-1:0]  m_res [MAX_VL];
    bit                m_pred [MAX_VL];
    bit                m_wen [MAX_VL];
    logic [40:0]       m_ctrl;
    logic [MAX_VL-1:0] ref_mask = '0;

    // Per-cycle comparison of DUT outputs against the model's schedule.
    always @(negedge clk) begin
        int k;
        bit exp_w;
        if (active) begin
            k = cyc - t_acc;
            if (k >= 1) begin
                chk("rd_en", rf_rd_en, (k <= m_n));
                if (k <= m_n) begin
                    chk("rd_addr_a", rf_rd_addr_a, m_vs1 * MAX_VL + k - 1);
                    chk("rd_addr_b", rf_rd_addr_b, m_vs2 * MAX_VL + k - 1);
                end
                if (k >= 2 && k <= m_n + 1) begin
                    chk("alu_a", alu_a, m_a[k-2]);
                    chk("alu_b", alu_b, m_b[k-2]);
                end
                exp_w = 1'b0;
                if (k >= 3 && k <= m_n + 2) exp_w = m_wen[k-3];
                chk("wr_en", rf_wr_en, exp_w);
                if (exp_w) begin
                    chk("wr_addr", rf_wr_addr, m_vd * MAX_VL + k - 3);
                    chk("wr_data", rf_wr_data, m_res[k-3]);
                end
                if (k <= done_k)
                    chk("alu_ctrl", {alu_addsub, alu_mux, alu_outctl, alu_bwctl, alu_cmpctl, alu_c}, m_ctrl);
                chk("done", done, (k == done_k));
                chk("ready", instr_ready, (k > done_k));
                if (done) done_at = k;
                if (k > done_k) active = 1'b0;
            end
        end
    end

    task automatic load_rf();
        @(negedge clk);
        tb_load = 1'b1;
        @(negedge clk);
        tb_load = 1'b0;
    endtask

    task automatic run_instr(input int vl, input int vd, input int vs1, input int vs2,
                             input bit sen, input logic [WIDTH-1:0] sc, input bit sub,
                             input bit cmpen, input logic [1:0] cc, input bit men);
        logic [2:0]        oc;
        logic [1:0]        bc;
        logic [WIDTH-1:0]  op2;
        logic [MAX_VL-1:0] old_mask;
        bit                eff_men;
        int                guard;
        oc = 3'($urandom);
        bc = 2'($urandom);
`ifdef VALU_MASKED_EXEC_EN
        eff_men = men;
`else
        eff_men = 1'b0 & men;
`endif
        @(negedge clk);
        chk("ready_idle", instr_ready, 1);
        instr_valid = 1'b1;           instr_vl = VLW'(vl);
        instr_vd = RW'(vd);           instr_vs1 = RW'(vs1);       instr_vs2 = RW'(vs2);
        instr_scalar_en = sen;        instr_scalar = sc;          instr_addsub = sub;
        instr_outctl = oc;            instr_bwctl = bc;           instr_cmpctl = cc;
        instr_cmp_en = cmpen;
`ifdef VALU_MASKED_EXEC_EN
        instr_mask_en = men;
`endif
        // model: results computed from the pre-instruction register image
        m_n = (vl > MAX_VL) ? MAX_VL : vl;
        m_vs1 = vs1; m_vs2 = vs2; m_vd = vd;
        old_mask = ref_mask;
        for (int i = 0; i < MAX_VL; i++) begin
            m_a[i]    = ref_mem[vs1 * MAX_VL + i];
            m_b[i]    = ref_mem[vs2 * MAX_VL + i];
            op2       = sen ? sc : m_b[i];
            m_res[i]  = alu_fn(m_a[i], op2, sub);
            m_pred[i] = pred_fn(m_a[i], op2, cc);
            m_wen[i]  = !cmpen && (!eff_men || old_mask[i]);
        end
        m_ctrl  = {sub, sen, oc, bc, cc, sc};
        done_k  = (m_n == 0) ? 2 : m_n + 3;
        done_at = -1;
        t_acc   = cyc;
        n_rd = 0; n_wr = 0;
        active  = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr_vl = VLW'($urandom);  instr_vd = RW'($urandom);  instr_vs1 = RW'($urandom);
        instr_vs2 = RW'($urandom);  instr_scalar = $urandom;   instr_scalar_en = 1'($urandom);
        instr_addsub = 1'($urandom); instr_cmpctl = 2'($urandom); instr_cmp_en = 1'($urandom);
        guard = 0;
        while (active && guard < 40) begin
            @(posedge clk);
            guard++;
        end
        if (active) begin
            total++; bad++;
            $display("FAIL timeout: instruction did not complete within 40 cycles");
            active = 1'b0;
        end
        for (int i = 0; i < m_n; i++)
            if (m_wen[i]) ref_mem[vd * MAX_VL + i] = m_res[i];
        if (cmpen) begin
            ref_mask = '0;
            for (int i = 0; i < m_n; i++)
                if (!eff_men || old_mask[i]) ref_mask[i] = m_pred[i];
        end
        @(negedge clk);
        chk("mask_out", mask_out, ref_mask);
        for (int i = 0; i < MAX_VL; i++)
            chk("vd_contents", mem[vd * MAX_VL + i], ref_mem[vd * MAX_VL + i]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int j = 0; j < DEPTH; j++) ref_mem[j] = $urandom;
        repeat (2) @(negedge clk);
        // reset state
        chk("rst_ready", instr_ready, 1);
        chk("rst_rd_en", rf_rd_en, 0);
        chk("rst_wr_en", rf_wr_en, 0);
        chk("rst_done", done, 0);
        chk("rst_mask", mask_out, 0);
        chk("rst_addr", {rf_rd_addr_a, rf_rd_addr_b, rf_wr_addr}, 0);
        chk("rst_data", {alu_a, alu_b, alu_c, rf_wr_data}, 0);
        chk("rst_ctrl", {alu_addsub, alu_mux, alu_outctl, alu_bwctl, alu_cmpctl}, 0);
        reset = 1'b0;
        load_rf();

        // add: {1,2,3,4} + {10,20,30,40}
        for (int i = 0; i < MAX_VL; i++) begin
            ref_mem[1 * MAX_VL + i] = WIDTH'(i + 1);
            ref_mem[2 * MAX_VL + i] = WIDTH'(10 * (i + 1));
            ref_mem[4 * MAX_VL + i] = WIDTH'(i + 5);
            ref_mem[6 * MAX_VL + i] = WIDTH'(100 + i);
            ref_mem[7 * MAX_VL + i] = (i % 2 == 0 && i < 6) ? WIDTH'(100 + i) : WIDTH'(200 + i);
        end
        load_rf();
        run_instr(4, 3, 1, 2, 0, 0, 0, 0, 2'd0, 0);
        chk("add_e0", mem[3 * MAX_VL + 0], 11);
        chk("add_e1", mem[3 * MAX_VL + 1], 22);
        chk("add_e2", mem[3 * MAX_VL + 2], 33);
        chk("add_e3", mem[3 * MAX_VL + 3], 44);
        chk("add_done_cycle", done_at, 7);
        chk("add_writes", n_wr, 4);

        // scalar subtract: (i+5) - 5 = i
        run_instr(8, 5, 4, 2, 1, 5, 1, 0, 2'd0, 0);
        for (int i = 0; i < MAX_VL; i++) chk("ssub_elem", mem[5 * MAX_VL + i], i);
        chk("ssub_done_cycle", done_at, 11);

        // compare equality over 6 elements
        run_instr(6, 9, 6, 7, 0, 0, 0, 1, 2'd0, 0);
        chk("cmp_mask", mask_out, 8'b00010101);
        chk("cmp_no_writes", n_wr, 0);

        // vl = 0 and clamped vl = 15
        run_instr(0, 10, 1, 2, 0, 0, 0, 0, 2'd0, 0);
        chk("vl0_reads", n_rd, 0);
        chk("vl0_writes", n_wr, 0);
        chk("vl0_done_cycle", done_at, 2);
        run_instr(15, 11, 1, 2, 0, 0, 0, 0, 2'd0, 0);
        chk("vl15_reads", n_rd, 8);
        chk("vl15_writes", n_wr, 8);

        // reset during cycle 3 of a vl=8 add
        @(negedge clk);
        instr_valid = 1'b1; instr_vl = 4'd8; instr_vd = 5'd12; instr_vs1 = 5'd1; instr_vs2 = 5'd2;
        instr_scalar_en = 1'b0; instr_addsub = 1'b0; instr_cmp_en = 1'b0;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        n_rd = 0; n_wr = 0;
        chk("midrst_ready", instr_ready, 1);
        chk("midrst_strobes", {rf_rd_en, rf_wr_en, done}, 0);
        @(negedge clk);
        chk("midrst_mask", mask_out, 0);
        chk("midrst_outs", {rf_wr_addr, rf_wr_data, alu_a, alu_c}, 0);
        reset = 1'b0;
        ref_mask = '0;
        repeat (12) @(negedge clk);
        chk("midrst_no_reads", n_rd, 0);
        chk("midrst_no_writes", n_wr, 0);
        chk("midrst_idle", instr_ready, 1);
        for (int i = 0; i < MAX_VL; i++)
            chk("midrst_vd_untouched", mem[12 * MAX_VL + i], ref_mem[12 * MAX_VL + i]);
        run_instr(8, 12, 1, 2, 0, 0, 0, 0, 2'd0, 0);
        chk("post_rst_e7", mem[12 * MAX_VL + 7], 88);

`ifdef VALU_MASKED_EXEC_EN
        // build mask 8'hA5, then a masked add into a known destination
        for (int i = 0; i < MAX_VL; i++) begin
            ref_mem[13 * MAX_VL + i] = WIDTH'(i);
            ref_mem[14 * MAX_VL + i] = ((8'hA5 >> i) & 1) != 0 ? WIDTH'(i) : WIDTH'(i + 1000);
            ref_mem[15 * MAX_VL + i] = 32'hDEAD0000 + WIDTH'(i);
        end
        load_rf();
        run_instr(8, 16, 13, 14, 0, 0, 0, 1, 2'd0, 0);
        chk("men_mask_setup", mask_out, 8'hA5);
        run_instr(8, 15, 1, 2, 0, 0, 0, 0, 2'd0, 1);
        chk("men_writes", n_wr, 4);
        chk("men_e0", mem[15 * MAX_VL + 0], 11);
        chk("men_e1", mem[15 * MAX_VL + 1], 32'hDEAD0001);
        chk("men_e7", mem[15 * MAX_VL + 7], 88);
`endif

        // randomized instructions, including overlapping source/destination
        for (int n = 0; n < 40; n++) begin
            int vs1r;
            vs1r = int'($urandom_range(0, 31));
            run_instr(int'($urandom_range(0, 15)),
                      ($urandom_range(0, 3) == 0) ? vs1r : int'($urandom_range(0, 31)),
                      vs1r, int'($urandom_range(0, 31)),
                      1'($urandom), $urandom_range(0, 3) == 0 ? WIDTH'($urandom_range(0, 7)) : $urandom,
                      1'($urandom), $urandom_range(0, 3) == 0, 2'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
